// File: rtl/mult_arbiter_if.sv
// Bundle between mult_arbiter, its two requesters and the shared multiplier.
// slave: arbiter side; master: requesters plus multiplier side.
interface mult_arbiter_if #(
  parameter int WIDTH = 7
);

  logic                 req0;
  logic                 req1;
  logic [WIDTH-1:0]     a0;
  logic [WIDTH-1:0]     b0;
  logic [WIDTH-1:0]     a1;
  logic [WIDTH-1:0]     b1;
  logic                 ack0;
  logic                 ack1;
  logic                 rsp_valid0;
  logic                 rsp_valid1;
  logic [2*WIDTH-1:0]   rsp_product;
  logic                 rsp_err;
  logic                 busy;
  logic                 mult_clear;
  logic                 mult_start;
  logic [WIDTH-1:0]     mult_a;
  logic [WIDTH-1:0]     mult_b;
  logic [2*WIDTH-1:0]   mult_product;
  logic                 mult_done;

  modport slave (
    input  req0, req1,
    input  a0, b0, a1, b1,
    input  mult_product, mult_done,
    output ack0, ack1,
    output rsp_valid0, rsp_valid1,
    output rsp_product, rsp_err,
    output busy,
    output mult_clear, mult_start,
    output mult_a, mult_b
  );

  modport master (
    output req0, req1,
    output a0, b0, a1, b1,
    output mult_product, mult_done,
    input  ack0, ack1,
    input  rsp_valid0, rsp_valid1,
    input  rsp_product, rsp_err,
    input  busy,
    input  mult_clear, mult_start,
    input  mult_a, mult_b
  );

endinterface

// File: rtl/mult_arbiter.sv
// Round-robin share of one sequential signed multiplier by two requesters.
// Ports: clock, reset (async, active-low), bus (mult_arbiter_if.slave).
module mult_arbiter #(
  parameter int WIDTH   = 7,
  parameter int TIMEOUT = 31
) (
  input logic           clock,
  input logic           reset,
  mult_arbiter_if.slave bus
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t               state;
  logic                 last_grant;
  logic                 gnt;
  logic [7:0]           wdog;
  logic [7:0]           wdog_inc;
  logic                 any_req;
  logic                 pick1;

  logic                 ack0_q;
  logic                 ack1_q;
  logic                 rv0_q;
  logic                 rv1_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic                 err_q;
  logic                 busy_q;
  logic                 clr_q;
  logic                 start_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;

  assign any_req  = bus.req0 | bus.req1;
  // On a tie the requester that did not win last time goes next.
  assign pick1    = bus.req1 & (~bus.req0 | ~last_grant);
  // Abort once the incremented count reaches TIMEOUT: WAIT lasts
  // at most TIMEOUT cycles.
  assign wdog_inc = wdog + 8'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      wdog       <= 8'd0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
      prod_q     <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      clr_q      <= 1'b0;
      start_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      clr_q   <= 1'b0;
      start_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt        <= pick1;
            last_grant <= pick1;
            a_q        <= pick1 ? bus.a1 : bus.a0;
            b_q        <= pick1 ? bus.b1 : bus.b0;
            ack0_q     <= ~pick1;
            ack1_q     <= pick1;
            clr_q      <= 1'b1;
            busy_q     <= 1'b1;
            state      <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          start_q <= 1'b1;
          state   <= S_START;
        end
        S_START: begin
          wdog  <= 8'd0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          wdog <= wdog_inc;
          if (bus.mult_done) begin
            prod_q <= bus.mult_product;
            err_q  <= 1'b0;
            rv0_q  <= ~gnt;
            rv1_q  <= gnt;
            state  <= S_RESP;
          end else if (wdog_inc == TO) begin
            prod_q <= '0;
            err_q  <= 1'b1;
            rv0_q  <= ~gnt;
            rv1_q  <= gnt;
            state  <= S_RESP;
          end
        end
        S_RESP: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.rsp_valid0  = rv0_q;
  assign bus.rsp_valid1  = rv1_q;
  assign bus.rsp_product = prod_q;
  assign bus.rsp_err     = err_q;
  assign bus.busy        = busy_q;
  assign bus.mult_clear  = clr_q;
  assign bus.mult_start  = start_q;
  assign bus.mult_a      = a_q;
  assign bus.mult_b      = b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural multiplier stub.
// Ports of dut: clock, reset, bus (interface instance).
module tb_mult_arbiter;

  logic clock;
  logic reset;

  mult_arbiter_if #(.WIDTH(7)) bus ();

  mult_arbiter #(
    .WIDTH   (7),
    .TIMEOUT (31)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks   = 0;
  int failures = 0;

  // multiplier stub
  logic       hang;
  logic       keep_stale;
  int         lat;
  logic [7:0] cnt;
  logic       mbusy;

  function automatic logic [13:0] smul(
    input logic signed [6:0] a,
    input logic signed [6:0] b
  );
    logic signed [13:0] x;
    logic signed [13:0] y;
    x = a;
    y = b;
    return x * y;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      bus.mult_done    <= 1'b0;
      bus.mult_product <= '0;
      mbusy            <= 1'b0;
      cnt              <= 8'd0;
    end else if (bus.mult_start) begin
      bus.mult_done <= 1'b0;
      cnt           <= lat[7:0];
      mbusy         <= 1'b1;
    end else if (bus.mult_clear) begin
      if (!keep_stale) bus.mult_done <= 1'b0;
      mbusy <= 1'b0;
    end else if (mbusy && !hang) begin
      if (cnt == 8'd0) begin
        bus.mult_done    <= 1'b1;
        bus.mult_product <= smul(bus.mult_a, bus.mult_b);
        mbusy            <= 1'b0;
      end else begin
        cnt <= cnt - 8'd1;
      end
    end
  end

  // event monitor
  int          cyc       = 0;
  int          n_ack0    = 0;
  int          n_ack1    = 0;
  int          n_rsp     = 0;
  int          n_both    = 0;
  int          start_cyc = 0;
  int          rsp_cyc   = 0;
  int          bad_seq   = 0;
  logic        clr_seen  = 1'b0;
  int          id_q[$];
  logic [13:0] prod_q[$];
  logic        err_q[$];

  always @(negedge clock) begin
    cyc++;
    if (bus.ack0 === 1'b1) n_ack0++;
    if (bus.ack1 === 1'b1) n_ack1++;
    if (bus.mult_clear === 1'b1) clr_seen = 1'b1;
    if (bus.mult_start === 1'b1) begin
      start_cyc = cyc;
      if (!clr_seen) bad_seq++;
      clr_seen = 1'b0;
    end
    if (bus.rsp_valid0 === 1'b1 && bus.rsp_valid1 === 1'b1) n_both++;
    if (bus.rsp_valid0 === 1'b1 || bus.rsp_valid1 === 1'b1) begin
      n_rsp++;
      rsp_cyc = cyc;
      id_q.push_back(bus.rsp_valid1 ? 1 : 0);
      prod_q.push_back(bus.rsp_product);
      err_q.push_back(bus.rsp_err);
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  function automatic logic [35:0] all_out();
    return {bus.ack0, bus.ack1, bus.rsp_valid0, bus.rsp_valid1,
            bus.rsp_product, bus.rsp_err, bus.busy,
            bus.mult_clear, bus.mult_start, bus.mult_a, bus.mult_b};
  endfunction

  task automatic do_req(input int id,
                        input logic [6:0] a,
                        input logic [6:0] b,
                        input string tag);
    int k;
    logic seen;
    k = 0;
    seen = 1'b0;
    if (id == 0) begin
      bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1;
    end else begin
      bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1;
    end
    while (!seen && k < 20) begin
      tick(1);
      k++;
      seen = (id == 0) ? bus.ack0 : bus.ack1;
    end
    chk({tag, "_ack"}, seen, 1'b1);
    chk({tag, "_clr"}, bus.mult_clear, 1'b1);
    chk({tag, "_opa"}, bus.mult_a, a);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic do_both(input logic [6:0] a0, input logic [6:0] b0,
                         input logic [6:0] a1, input logic [6:0] b1,
                         input string tag);
    int k;
    logic d0;
    logic d1;
    k = 0;
    d0 = 1'b0;
    d1 = 1'b0;
    bus.a0 = a0; bus.b0 = b0;
    bus.a1 = a1; bus.b1 = b1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    while (!(d0 && d1) && k < 60) begin
      tick(1);
      k++;
      if (bus.ack0) begin bus.req0 = 1'b0; d0 = 1'b1; end
      if (bus.ack1) begin bus.req1 = 1'b0; d1 = 1'b1; end
    end
    chk({tag, "_acks"}, {d0, d1}, 2'b11);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int budget,
                          input string tag);
    int k;
    k = 0;
    while (n_rsp < target && k < budget) begin
      tick(1);
      k++;
    end
    chk({tag, "_rsp"}, n_rsp, target);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "tb_mult_arbiter stuck");
  end

  initial begin
    reset      = 1'b0;
    hang       = 1'b0;
    keep_stale = 1'b0;
    lat        = 2;
    bus.req0   = 1'b0;
    bus.req1   = 1'b0;
    bus.a0     = '0;
    bus.b0     = '0;
    bus.a1     = '0;
    bus.b1     = '0;
    tick(3);
    chk("reset_outs", all_out(), 36'd0);
    reset = 1'b1;
    tick(2);
    chk("idle_busy", bus.busy, 1'b0);

    // 1: -8 * -5
    do_req(0, 7'h78, 7'h7B, "t1");
    chk("t1_busy", bus.busy, 1'b1);
    wait_rsp(1, 40, "t1");
    chk("t1_id", id_q[0], 0);
    chk("t1_prod", prod_q[0], 14'd40);
    chk("t1_err", err_q[0], 1'b0);
    chk("t1_ack1", n_ack1, 0);
    tick(3);
    chk("t1_hold", bus.rsp_product, 14'd40);
    chk("t1_idle", bus.busy, 1'b0);

    // 2: 5 * -11
    do_req(1, 7'h05, 7'h75, "t2");
    wait_rsp(2, 40, "t2");
    chk("t2_id", id_q[1], 1);
    chk("t2_prod", prod_q[1], 14'b11111111001001);
    chk("t2_err", err_q[1], 1'b0);

    // 3a: tie with last_grant=1 -> 0 then 1
    do_both(7'h03, 7'h07, 7'h7C, 7'h06, "t3a");
    wait_rsp(4, 60, "t3a");
    chk("t3a_id0", id_q[2], 0);
    chk("t3a_p0", prod_q[2], 14'd21);
    chk("t3a_id1", id_q[3], 1);
    chk("t3a_p1", prod_q[3], 14'h3FE8);

    // single req0 so the next tie favours req1
    do_req(0, 7'h02, 7'h7D, "t3s");
    wait_rsp(5, 40, "t3s");
    chk("t3s_prod", prod_q[4], 14'h3FFA);

    // 3b: tie with last_grant=0 -> 1 then 0; extreme operands
    do_both(7'h40, 7'h40, 7'h3F, 7'h40, "t3b");
    wait_rsp(7, 60, "t3b");
    chk("t3b_id0", id_q[5], 1);
    chk("t3b_p0", prod_q[5], 14'h3040);
    chk("t3b_id1", id_q[6], 0);
    chk("t3b_p1", prod_q[6], 14'h1000);

    // 4: hung multiplier -> watchdog
    hang = 1'b1;
    do_req(0, 7'h01, 7'h01, "t4");
    wait_rsp(8, 80, "t4");
    chk("t4_id", id_q[7], 0);
    chk("t4_err", err_q[7], 1'b1);
    chk("t4_prod", prod_q[7], 14'd0);
    chk("t4_lat", rsp_cyc - start_cyc, 32);
    hang = 1'b0;
    do_req(1, 7'h7D, 7'h7D, "t4n");
    wait_rsp(9, 40, "t4n");
    chk("t4n_id", id_q[8], 1);
    chk("t4n_prod", prod_q[8], 14'd9);
    chk("t4n_err", err_q[8], 1'b0);

    // 5: reset during WAIT
    hang = 1'b1;
    do_req(1, 7'h09, 7'h09, "t5");
    tick(4);
    reset = 1'b0;
    #1;
    chk("t5_outs", all_out(), 36'd0);
    tick(2);
    reset = 1'b1;
    hang  = 1'b0;
    tick(3);
    chk("t5_norsp", n_rsp, 9);
    do_req(1, 7'h7F, 7'h7F, "t5n");
    wait_rsp(10, 40, "t5n");
    chk("t5n_id", id_q[9], 1);
    chk("t5n_prod", prod_q[9], 14'd1);
    chk("t5n_err", err_q[9], 1'b0);

    // 6: stale done held through CLEAR/START
    keep_stale = 1'b1;
    lat        = 3;
    do_req(0, 7'h79, 7'h09, "t6");
    wait_rsp(11, 40, "t6");
    chk("t6_id", id_q[10], 0);
    chk("t6_prod", prod_q[10], 14'h3FC1);
    chk("t6_lat", rsp_cyc - start_cyc, 6);
    keep_stale = 1'b0;
    tick(3);

    chk("clr_before_start", bad_seq, 0);
    chk("rsp_overlap", n_both, 0);
    chk("n_ack0", n_ack0, 6);
    chk("n_ack1", n_ack1, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
